// File: rtl/zbuff_pkg.sv
// Shared constants and types for the zbuff_tile depth-test / tile framebuffer stage.
package zbuff_pkg;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int TILE_W = 16;
  localparam int TILE_H = 16;

  localparam int NPIX = TILE_W * TILE_H;
  localparam int AW   = $clog2(NPIX);
  localparam int XW   = $clog2(TILE_W);
  localparam int YW   = $clog2(TILE_H);
  localparam int PW   = SIGFIG - RADIX;  // integer part of a hit coordinate

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic signed [SIGFIG-1:0] DEPTH_FAR = {1'b0, {(SIGFIG-1){1'b1}}};

  typedef struct packed {
    logic signed [SIGFIG-1:0]      depth;
    logic [COLORS-1:0][SIGFIG-1:0] color;
  } pixel_t;

  localparam pixel_t PIXEL_FAR  = {DEPTH_FAR, {(COLORS*SIGFIG){1'b0}}};
  localparam pixel_t PIXEL_ZERO = {(SIGFIG*(COLORS+1)){1'b0}};

  typedef enum logic {
    ST_CLEAR  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    logic [15:0] r;
    if (en && (v != 16'hFFFF)) begin
      r = v + 16'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction
endpackage

// File: rtl/zbuff_mem.sv
// Tile storage: port A has a write and a synchronous read (separate addresses),
// port B is a synchronous read-only host port. Reads return pre-write contents.
module zbuff_mem
  import zbuff_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_a_raddr,
  output pixel_t        o_a_rdata,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_waddr,
  input  pixel_t        i_a_wdata,
  input  logic          i_b_en,
  input  logic [AW-1:0] i_b_addr,
  output pixel_t        o_b_rdata
);
  pixel_t r_mem [NPIX];
  pixel_t r_a_rdata;
  pixel_t r_b_rdata;

  // Port A: pipeline write and read-before-write read
  always_ff @(posedge clk) begin
    if (i_a_we) begin
      r_mem[i_a_waddr] <= i_a_wdata;
    end
    r_a_rdata <= r_mem[i_a_raddr];
  end

  // Port B: host read, output held between requests
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_rdata <= PIXEL_ZERO;
    end else if (i_b_en) begin
      r_b_rdata <= r_mem[i_b_addr];
    end else begin
      r_b_rdata <= r_b_rdata;
    end
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;
endmodule

// File: rtl/zbuff_tile.sv
// Depth-test stage behind rast: keeps the nearest-z colour per pixel of one tile,
// with a clear FSM, a host read port and saturating hit statistics.
module zbuff_tile
  import zbuff_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hit_valid_R18H,
  input  logic signed [AXIS-1:0][SIGFIG-1:0] hit_R18S,
  input  logic [COLORS-1:0][SIGFIG-1:0]    color_R18U,
  input  logic                             clear_RnnnnH,
  output logic                             busy_RnnnnH,
  input  logic                             rd_en_RnnnnH,
  input  logic [AW-1:0]                    rd_addr_RnnnnU,
  output logic                             rd_valid_RnnnnH,
  output logic [COLORS-1:0][SIGFIG-1:0]    rd_color_RnnnnU,
  output logic signed [SIGFIG-1:0]         rd_depth_RnnnnS,
  output logic [15:0]                      cnt_written_RnnnnU,
  output logic [15:0]                      cnt_occluded_RnnnnU,
  output logic [15:0]                      cnt_dropped_RnnnnU
);
  state_t                        r_state;
  logic [AW-1:0]                 r_clr_ptr;
  logic                          r_clr_pend, r_busy, r_rd_valid;
  logic                          r_s19_vld, r_s20_vld, r_fwd_vld;
  logic [PW-1:0]                 r_s19_px, r_s19_py;
  logic signed [SIGFIG-1:0]      r_s19_z, r_s20_z, r_fwd_depth;
  logic [COLORS-1:0][SIGFIG-1:0] r_s19_color, r_s20_color;
  logic [AW-1:0]                 r_s20_addr, r_fwd_addr;
  logic [15:0]                   r_cnt_wr, r_cnt_occ, r_cnt_drop;
  logic                          w_s19_in_tile, w_s19_issue, w_s19_drop;
  logic [AW-1:0]                 w_s19_addr, w_mem_waddr;
  logic signed [SIGFIG-1:0]      w_s20_old;
  logic                          w_s20_wr, w_s20_occ, w_mem_we;
  pixel_t                        w_a_rdata, w_b_rdata, w_mem_wdata;
  logic                          w_unused_bits;

  assign w_unused_bits = ^{hit_R18S[0][RADIX-1:0], hit_R18S[1][RADIX-1:0], w_a_rdata.color};

  // R18 -> R19: keep only the floor-shifted integer part of x/y
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s19_vld <= 1'b0;
    end else begin
      r_s19_vld <= hit_valid_R18H;
    end
    r_s19_px    <= hit_R18S[0][SIGFIG-1:RADIX];
    r_s19_py    <= hit_R18S[1][SIGFIG-1:RADIX];
    r_s19_z     <= hit_R18S[2];
    r_s19_color <= color_R18U;
  end

  // R19: in-tile means non-negative and below the tile size, i.e. high bits all zero
  always_comb begin
    w_s19_in_tile = (r_s19_px[PW-1:XW] == {(PW-XW){1'b0}}) &&
                    (r_s19_py[PW-1:YW] == {(PW-YW){1'b0}});
    w_s19_addr    = {r_s19_py[YW-1:0], r_s19_px[XW-1:0]};
    if (r_s19_vld && !r_busy && w_s19_in_tile) begin
      w_s19_issue = 1'b1;
      w_s19_drop  = 1'b0;
    end else begin
      w_s19_issue = 1'b0;
      w_s19_drop  = r_s19_vld;
    end
  end

  // R19 -> R20 pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s20_vld <= 1'b0;
    end else begin
      r_s20_vld <= w_s19_issue;
    end
    r_s20_addr  <= w_s19_addr;
    r_s20_z     <= r_s19_z;
    r_s20_color <= r_s19_color;
  end

  // R20: the RAM read missed last cycle's write to the same pixel, so forward it
  always_comb begin
    if (r_fwd_vld && (r_fwd_addr == r_s20_addr)) begin
      w_s20_old = r_fwd_depth;
    end else begin
      w_s20_old = w_a_rdata.depth;
    end
    w_s20_wr  = r_s20_vld && (r_s20_z < w_s20_old);
    w_s20_occ = r_s20_vld && !w_s20_wr;
  end

  always_comb begin
    if (r_state == ST_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_clr_ptr;
      w_mem_wdata = PIXEL_FAR;
    end else begin
      w_mem_we          = w_s20_wr;
      w_mem_waddr       = r_s20_addr;
      w_mem_wdata.depth = r_s20_z;
      w_mem_wdata.color = r_s20_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_vld <= 1'b0;
    end else begin
      r_fwd_vld <= w_s20_wr;
    end
    r_fwd_addr  <= r_s20_addr;
    r_fwd_depth <= r_s20_z;
  end

  // Clear FSM: a request in ACTIVE waits until no hit can still write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= {AW{1'b0}};
      r_clr_pend <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr  <= r_clr_ptr + {{(AW-1){1'b0}}, 1'b1};
          r_clr_pend <= 1'b0;
          if (r_clr_ptr == LAST_ADDR) begin
            r_state <= ST_ACTIVE;
            r_busy  <= 1'b0;
          end else begin
            r_busy  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if ((clear_RnnnnH || r_clr_pend) && !w_s19_issue && !r_s20_vld) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= {AW{1'b0}};
            r_clr_pend <= 1'b0;
            r_busy     <= 1'b1;
          end else if (clear_RnnnnH) begin
            r_clr_pend <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_busy     <= r_clr_pend;
          end
        end
        default: begin
          r_state    <= ST_CLEAR;
          r_clr_ptr  <= {AW{1'b0}};
          r_clr_pend <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  // Statistics and host read handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_wr   <= 16'd0;
      r_cnt_occ  <= 16'd0;
      r_cnt_drop <= 16'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_cnt_wr   <= sat_inc(r_cnt_wr, w_s20_wr);
      r_cnt_occ  <= sat_inc(r_cnt_occ, w_s20_occ);
      r_cnt_drop <= sat_inc(r_cnt_drop, w_s19_drop);
      r_rd_valid <= rd_en_RnnnnH;
    end
  end

  zbuff_mem u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_a_raddr (w_s19_addr),
    .o_a_rdata (w_a_rdata),
    .i_a_we    (w_mem_we),
    .i_a_waddr (w_mem_waddr),
    .i_a_wdata (w_mem_wdata),
    .i_b_en    (rd_en_RnnnnH),
    .i_b_addr  (rd_addr_RnnnnU),
    .o_b_rdata (w_b_rdata)
  );

  assign busy_RnnnnH         = r_busy;
  assign rd_valid_RnnnnH     = r_rd_valid;
  assign rd_color_RnnnnU     = w_b_rdata.color;
  assign rd_depth_RnnnnS     = w_b_rdata.depth;
  assign cnt_written_RnnnnU  = r_cnt_wr;
  assign cnt_occluded_RnnnnU = r_cnt_occ;
  assign cnt_dropped_RnnnnU  = r_cnt_drop;
endmodule

// File: tb/tb_zbuff_tile.sv
// Directed bench for zbuff_tile: hand-computed expectations checked with immediate assertions.
module tb_zbuff_tile;
  logic             clk = 1'b0;
  logic             rst, hit_valid, clear, rd_en;
  logic [2:0][23:0] hit, color;
  logic [7:0]       rd_addr;
  logic             busy, rd_valid;
  logic [2:0][23:0] rd_color;
  logic [23:0]      rd_depth;
  logic [15:0]      cnt_wr, cnt_occ, cnt_drop;
  int               errors = 0;
  int               checks = 0;
  int               n;
  int               bad;

  always #5 clk = ~clk;

  zbuff_tile dut (
    .clk                 (clk),
    .rst                 (rst),
    .hit_valid_R18H      (hit_valid),
    .hit_R18S            (hit),
    .color_R18U          (color),
    .clear_RnnnnH        (clear),
    .busy_RnnnnH         (busy),
    .rd_en_RnnnnH        (rd_en),
    .rd_addr_RnnnnU      (rd_addr),
    .rd_valid_RnnnnH     (rd_valid),
    .rd_color_RnnnnU     (rd_color),
    .rd_depth_RnnnnS     (rd_depth),
    .cnt_written_RnnnnU  (cnt_wr),
    .cnt_occluded_RnnnnU (cnt_occ),
    .cnt_dropped_RnnnnU  (cnt_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_hit(input logic [23:0] x, input logic [23:0] y, input logic [23:0] z,
                           input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2);
    hit_valid = 1'b1;
    hit[0] = x; hit[1] = y; hit[2] = z;
    color[0] = c0; color[1] = c1; color[2] = c2;
  endtask

  task automatic check_px(input string tag, input logic [7:0] a, input logic [23:0] d,
                          input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2);
    rd_addr = a;
    rd_en   = 1'b1;
    @(negedge clk);
    rd_en   = 1'b0;
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_depth"}, rd_depth, d);
    check({tag, "_c0"}, rd_color[0], c0);
    check({tag, "_c1"}, rd_color[1], c1);
    check({tag, "_c2"}, rd_color[2], c2);
  endtask

  task automatic check_cnt(input string tag, input int w, input int o, input int d);
    check({tag, "_written"}, cnt_wr, w);
    check({tag, "_occluded"}, cnt_occ, o);
    check({tag, "_dropped"}, cnt_drop, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hit_valid = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = 8'd0;
    hit = '0; color = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_depth", rd_depth, 0);
    check("rst_rd_color", rd_color[0], 0);
    check_cnt("rst", 0, 0, 0);

    // busy must last exactly 256 cycles after rst falls
    rst = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("init_busy_len", n, 256);
    check_px("clr37", 8'd37, 24'h7FFFFF, 0, 0, 0);
    @(negedge clk);
    check("rd_valid_idle", rd_valid, 0);

    // single hit at (5,3) -> address 53
    drive_hit(24'h001400, 24'h000C00, 24'd100, 24'd1, 24'd2, 24'd3);
    @(negedge clk);
    hit_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_px("h53", 8'd53, 24'd100, 24'd1, 24'd2, 24'd3);
    check_cnt("h53", 1, 0, 0);

    // back-to-back to (2,2) -> address 34: 50 wins, 40 wins (forwarded), 45 loses
    drive_hit(24'h000800, 24'h000800, 24'd50, 24'd10, 24'd11, 24'd12);
    @(negedge clk);
    drive_hit(24'h000800, 24'h000800, 24'd40, 24'd20, 24'd21, 24'd22);
    @(negedge clk);
    drive_hit(24'h000800, 24'h000800, 24'd45, 24'd30, 24'd31, 24'd32);
    @(negedge clk);
    hit_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_px("b2b", 8'd34, 24'd40, 24'd20, 24'd21, 24'd22);
    check_cnt("b2b", 3, 1, 0);

    // equal depth is occluded
    drive_hit(24'h000800, 24'h000800, 24'd40, 24'd7, 24'd7, 24'd7);
    @(negedge clk);
    hit_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_px("eqz", 8'd34, 24'd40, 24'd20, 24'd21, 24'd22);
    check_cnt("eqz", 3, 2, 0);

    // x=-0.5 floors to -1 and x=16.0 is past the edge: both dropped
    drive_hit(24'hFFFE00, 24'h000800, 24'd1, 24'd9, 24'd9, 24'd9);
    @(negedge clk);
    drive_hit(24'h004000, 24'h000800, 24'd1, 24'd9, 24'd9, 24'd9);
    @(negedge clk);
    hit_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt("oot", 3, 2, 2);
    check_px("oot32", 8'd32, 24'h7FFFFF, 0, 0, 0);
    check_px("oot47", 8'd47, 24'h7FFFFF, 0, 0, 0);

    // clear while a hit sits in R19; a hit arriving during busy is dropped
    drive_hit(24'h000400, 24'h000400, 24'd10, 24'd5, 24'd5, 24'd5);
    @(negedge clk);
    hit_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_busy_pend", busy, 1);
    drive_hit(24'h001000, 24'h001000, 24'd1, 24'd6, 24'd6, 24'd6);
    @(negedge clk);
    hit_valid = 1'b0;
    n = 1;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("clr_busy_len_ok", (n >= 256 && n <= 258), 1);
    check_cnt("clr", 4, 2, 3);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      rd_addr = 8'(a);
      rd_en   = 1'b1;
      @(negedge clk);
      if (rd_valid !== 1'b1 || rd_depth !== 24'h7FFFFF || rd_color !== '0) bad++;
    end
    rd_en = 1'b0;
    check("clr_all_far", bad, 0);

    // tile is usable again after the clear
    drive_hit(24'h001400, 24'h000C00, 24'd7, 24'd8, 24'd8, 24'd8);
    @(negedge clk);
    hit_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_px("post", 8'd53, 24'd7, 24'd8, 24'd8, 24'd8);
    check_cnt("post", 5, 2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
